traffic_led_monitor: RTL and testbench
======================================

// Module: traffic_led_monitor
// PURPOSE
//  Receive-side checker for the traffic-light LED buses. Samples one 3-bit active-low
//  rotating LED bus (legal codes 110 -> 101 -> 011 -> 110) and measures each step's
//  dwell time in whole seconds. Flags illegal codes and out-of-order steps.
//  Sits beside the LED driver in the bench/debug path, one instance per direction.
// PARAMETERS
//  TIME_1S   5_000_000  clk cycles per second tick
//  CNT_W     24         width of the cycle prescaler; must satisfy 2^CNT_W > TIME_1S-1
//  DWELL_W   4          width of the seconds counter and dwell_s
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        synchronous reset, active low
//  led_in     in   3        monitored LED bus, active low, synchronous to clk
//  err_clr    in   1        1-cycle pulse; clears seq_err and code_err
//  locked     out  1        1 while in TRACK
//  dwell_vld  out  1        1-cycle pulse; dwell_s and dwell_frac are valid
//  dwell_s    out  DWELL_W  length of the completed step in seconds (saturating)
//  dwell_frac out  1        completed step was not an integer number of seconds
//  seq_err    out  1        sticky; legal code arrived out of rotation order
//  code_err   out  1        sticky; led_in held a code outside {110,101,011}
// BEHAVIOUR
//  - One clock domain. Reset is synchronous, active low, and is sampled on every clk edge.
//  - Reset values: locked=0, dwell_vld=0, dwell_s=0, dwell_frac=0, seq_err=0, code_err=0,
//    led_q=3'b111, cnt=0, sec=0, state=INIT.
//  - Reset asserted mid-operation returns every register to its reset value at the next edge.
//  - Definitions:
//    - led_q is the registered copy of led_in.
//    - A change is any cycle with led_in != led_q.
//    - A legal code is one of 110, 101, 011.
//    - rot(q) = {q[1:0], q[2]}.
//  - Prescaler (cnt, CNT_W bits):
//    - On a change: cnt<=0 and sec<=0.
//    - Else if cnt==TIME_1S-1: cnt<=0 and sec<=sec+1, saturating at 2^DWELL_W-1.
//    - Else: cnt<=cnt+1.
//  - The FSM updates led_q<=led_in every cycle except in reset.
//    - INIT: lasts one cycle, captures led_in, then goes to SYNC.
//    - SYNC: waits for the first change to a legal code, then goes to TRACK.
//      - No dwell is reported and no sequence check is made on that change.
//    - TRACK: on a change to a legal code, report the completed dwell.
//      - Also set seq_err if led_in != rot(led_q). The FSM stays in TRACK.
//    - Any state after INIT: if led_in holds an illegal code in any cycle, set code_err
//      and go to (or stay in) SYNC. No dwell is reported for that change.
//  - Dwell report (registered, so dwell_vld is high in the cycle after the change cycle):
//    - If cnt==TIME_1S-1 in the change cycle: dwell_s <= sat(sec+1), dwell_frac <= 0.
//    - Otherwise: dwell_s <= sec, dwell_frac <= 1.
//    - dwell_s and dwell_frac hold their values until the next report.
//  - Simultaneous events:
//    - A change in the same cycle as cnt wrap: the change wins. The dwell uses the
//      pre-wrap values, and cnt and sec restart at 0.
//    - err_clr in the same cycle as a new error: the error wins, and the flag remains 1.
//  - Example: a driver stepping every N*TIME_1S cycles yields dwell_s=N, dwell_frac=0.
// TESTING
//  1. TIME_1S=10, rst_n low for 3 cycles, led_in=110 held for 100 cycles
//     -> locked=0, no dwell_vld, both error flags 0.
//  2. TIME_1S=10, led_in rotates 110/101/011/110 every 20 cycles
//     -> locked=1 after the first change.
//     -> Each later change gives dwell_vld one cycle later with dwell_s=2, dwell_frac=0.
//  3. While locked, a step lasts 25 cycles
//     -> dwell_s=2, dwell_frac=1, no seq_err.
//  4. While locked, led_in goes 110 -> 011 (reverse step)
//     -> seq_err=1, dwell still reported, locked stays 1.
//     -> An err_clr pulse clears seq_err the next cycle.
//  5. While locked, led_in=100 for 1 cycle, then 101
//     -> code_err=1 and locked=0, then locked=1 after the next legal change.
//     -> No dwell is reported for the 100 code or for the first legal change after it.
//  6. DWELL_W=4, step held for 200 cycles (TIME_1S=10)
//     -> dwell_s=15 (saturated).
//     -> Assert rst_n low mid-step: all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/traffic_led_monitor.sv
// Receive-side checker for one rotating active-low traffic LED bus.
// Measures each step's dwell in whole seconds and flags illegal codes and out-of-order steps.
module traffic_led_monitor #(
  parameter int TIME_1S = 5_000_000,
  parameter int CNT_W   = 24,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         led_in,
  input  logic               err_clr,
  output logic               locked,
  output logic               dwell_vld,
  output logic [DWELL_W-1:0] dwell_s,
  output logic               dwell_frac,
  output logic               seq_err,
  output logic               code_err
);

  // state    | meaning
  // ST_INIT  | first cycle after reset, captures the bus
  // ST_SYNC  | waiting for a change to a legal code
  // ST_TRACK | locked to the rotation, reporting dwells
  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  localparam logic [CNT_W-1:0]   CNT_TOP = CNT_W'(TIME_1S - 1);
  localparam logic [DWELL_W-1:0] SEC_MAX = '1;

  logic [1:0]         state;
  logic [2:0]         led_q;
  logic [CNT_W-1:0]   cnt;
  logic [DWELL_W-1:0] sec;

  logic               change;
  logic               legal;
  logic               wrap;
  logic [2:0]         rot_q;
  logic [DWELL_W-1:0] sec_inc;
  logic               code_set;
  logic               seq_set;

  always_comb begin
    change   = (led_in != led_q);
    legal    = (led_in == 3'b110) || (led_in == 3'b101) || (led_in == 3'b011);
    wrap     = (cnt == CNT_TOP);
    rot_q    = {led_q[1:0], led_q[2]};
    sec_inc  = (sec == SEC_MAX) ? sec : sec + 1'b1;
    code_set = (state != ST_INIT) && !legal;
    seq_set  = (state == ST_TRACK) && legal && change && (led_in != rot_q);
  end

  assign locked = (state == ST_TRACK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      led_q      <= 3'b111;
      cnt        <= '0;
      sec        <= '0;
      dwell_vld  <= 1'b0;
      dwell_s    <= '0;
      dwell_frac <= 1'b0;
      seq_err    <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      led_q     <= led_in;
      dwell_vld <= 1'b0;

      // A change restarts the step timer even when it lands on a wrap cycle.
      if (change) begin
        cnt <= '0;
        sec <= '0;
      end else if (wrap) begin
        cnt <= '0;
        sec <= sec_inc;
      end else begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        ST_INIT: state <= ST_SYNC;
        ST_SYNC: begin
          if (legal && change) state <= ST_TRACK;
        end
        ST_TRACK: begin
          if (!legal) begin
            state <= ST_SYNC;
          end else if (change) begin
            dwell_vld <= 1'b1;
            if (wrap) begin
              dwell_s    <= sec_inc;
              dwell_frac <= 1'b0;
            end else begin
              dwell_s    <= sec;
              dwell_frac <= 1'b1;
            end
          end
        end
        default: state <= ST_INIT;
      endcase

      // A new error outranks a same-cycle clear.
      code_err <= code_set | (code_err & ~err_clr);
      seq_err  <= seq_set  | (seq_err  & ~err_clr);
    end
  end

endmodule

// File: tb/tb_traffic_led_monitor.sv
// Directed bench for traffic_led_monitor with TIME_1S=10: table of LED steps plus
// hand-written reset sequences.
module tb_traffic_led_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] led_in;
  logic       err_clr;
  logic       locked;
  logic       dwell_vld;
  logic [3:0] dwell_s;
  logic       dwell_frac;
  logic       seq_err;
  logic       code_err;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_led_monitor #(.TIME_1S(10), .CNT_W(24), .DWELL_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .led_in     (led_in),
    .err_clr    (err_clr),
    .locked     (locked),
    .dwell_vld  (dwell_vld),
    .dwell_s    (dwell_s),
    .dwell_frac (dwell_frac),
    .seq_err    (seq_err),
    .code_err   (code_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] led;
    logic       clr;
    int         hold;
    logic       locked;
    logic       vld;
    logic [3:0] s;
    logic       f;
    logic       seq;
    logic       code;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs[NVEC];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, "_locked"}, int'(locked),     int'(v.locked));
    check({tag, "_vld"},    int'(dwell_vld),  int'(v.vld));
    check({tag, "_s"},      int'(dwell_s),    int'(v.s));
    check({tag, "_frac"},   int'(dwell_frac), int'(v.f));
    check({tag, "_seq"},    int'(seq_err),    int'(v.seq));
    check({tag, "_code"},   int'(code_err),   int'(v.code));
  endtask

  // Drive one step: change cycle first, checked one edge later, then the rest of the hold.
  task automatic apply_step(input vec_t v, input int idx);
    int extra;
    led_in  = v.led;
    err_clr = v.clr;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check_outputs($sformatf("v%0d", idx), v);
    extra = 0;
    for (int k = 1; k < v.hold; k++) begin
      @(posedge clk); #1;
      if (dwell_vld) extra++;
    end
    check($sformatf("v%0d_no_extra_vld", idx), extra, 0);
  endtask

  initial begin
    vec_t zero_v;
    int   bad;

    //           led     clr  hold lk    vld   s      f     seq   code
    vecs[0]  = '{3'b101, 1'b0, 20, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b011, 1'b0, 20, 1'b1, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b110, 1'b0, 20, 1'b1, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'b101, 1'b0, 20, 1'b1, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'b011, 1'b0, 25, 1'b1, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b110, 1'b0, 20, 1'b1, 1'b1, 4'd2,  1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'b011, 1'b0, 20, 1'b1, 1'b1, 4'd2,  1'b0, 1'b1, 1'b0};
    vecs[7]  = '{3'b011, 1'b1,  1, 1'b1, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b110, 1'b0, 20, 1'b1, 1'b1, 4'd2,  1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'b011, 1'b1, 20, 1'b1, 1'b1, 4'd2,  1'b0, 1'b1, 1'b0};
    vecs[10] = '{3'b110, 1'b1, 20, 1'b1, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b100, 1'b0,  1, 1'b0, 1'b0, 4'd2,  1'b0, 1'b0, 1'b1};
    vecs[12] = '{3'b101, 1'b0, 20, 1'b1, 1'b0, 4'd2,  1'b0, 1'b0, 1'b1};
    vecs[13] = '{3'b011, 1'b0, 20, 1'b1, 1'b1, 4'd2,  1'b0, 1'b0, 1'b1};
    vecs[14] = '{3'b011, 1'b1,  1, 1'b1, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0};
    vecs[15] = '{3'b110, 1'b0, 15, 1'b1, 1'b1, 4'd2,  1'b1, 1'b0, 1'b0};
    vecs[16] = '{3'b101, 1'b0, 10, 1'b1, 1'b1, 4'd1,  1'b1, 1'b0, 1'b0};
    vecs[17] = '{3'b011, 1'b0,  5, 1'b1, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0};
    vecs[18] = '{3'b110, 1'b0, 20, 1'b1, 1'b1, 4'd0,  1'b1, 1'b0, 1'b0};
    vecs[19] = '{3'b111, 1'b0,  3, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1};
    vecs[20] = '{3'b110, 1'b0, 20, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1};
    vecs[21] = '{3'b101, 1'b1, 200, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{3'b011, 1'b0, 37, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{3'b101, 1'b0,  7, 1'b1, 1'b1, 4'd3,  1'b1, 1'b1, 1'b0};

    zero_v = '{3'b000, 1'b0, 0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

    rst_n   = 1'b0;
    led_in  = 3'b110;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", zero_v);
    rst_n = 1'b1;

    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (locked || dwell_vld || seq_err || code_err) bad++;
    end
    check("static_bus_quiet", bad, 0);

    for (int i = 0; i < NVEC; i++) apply_step(vecs[i], i);

    // Mid-step reset while seq_err and a dwell report are live.
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_outputs("mid_reset", zero_v);
    @(posedge clk); #1;
    rst_n = 1'b1;

    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (locked || dwell_vld || code_err) bad++;
    end
    check("post_reset_sync", bad, 0);

    led_in = 3'b011;
    @(posedge clk); #1;
    check("relock_locked", int'(locked), 1);
    check("relock_no_vld", int'(dwell_vld), 0);
    repeat (19) @(posedge clk);
    #1;
    led_in = 3'b110;
    @(posedge clk); #1;
    check("relock_dwell_vld", int'(dwell_vld), 1);
    check("relock_dwell_s", int'(dwell_s), 2);
    check("relock_dwell_frac", int'(dwell_frac), 0);
    check("relock_seq", int'(seq_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
